// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
// Holds the controller state enum, the XZR index and the per-stage control struct.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. XZR is never a real dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rm,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hit
);

  logic w_rn_match;
  logic w_rm_match;

  assign w_rn_match = (ex_rd == id_rn);
  assign w_rm_match = id_uses_rm && (ex_rd == id_rm);
  assign hit        = ex_mem_read && (ex_rd != XZR_IDX) && (w_rn_match || w_rm_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: memory-wait freeze, taken-branch flush, load-use bubble.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             dbg_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;

  logic              w_load_use;
  logic              w_mem_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  stage_ctrl_t       w_ifid, w_idex, w_exmem, w_memwb;

  load_use_detect u_load_use_detect (
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hit         (w_load_use)
  );

  assign w_mem_wait = mem_req && !mem_ready;

  // Mealy outputs: reset forces bubbles everywhere, then the priority chain applies.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    w_ifid        = '0;
    w_idex        = '0;
    w_exmem       = '0;
    w_memwb       = '0;
    if (!reset) begin
      pc_write      = 1'b0;
      w_ifid.flush  = 1'b1;
      w_idex.flush  = 1'b1;
      w_exmem.flush = 1'b1;
      w_memwb.flush = 1'b1;
    end else if (w_mem_wait) begin
      pc_write      = 1'b0;
      w_ifid.stall  = 1'b1;
      w_idex.stall  = 1'b1;
      w_exmem.stall = 1'b1;
      w_memwb.stall = 1'b1;
    end else if (mem_branch_taken) begin
      pc_sel_branch = 1'b1;
      w_ifid.flush  = 1'b1;
      w_idex.flush  = 1'b1;
      w_exmem.flush = 1'b1;
    end else if (w_load_use) begin
      pc_write     = 1'b0;
      w_ifid.stall = 1'b1;
      w_idex.flush = 1'b1;
    end
  end

  assign ifid_stall  = w_ifid.stall;
  assign idex_stall  = w_idex.stall;
  assign exmem_stall = w_exmem.stall;
  assign memwb_stall = w_memwb.stall;
  assign ifid_flush  = w_ifid.flush;
  assign idex_flush  = w_idex.flush;
  assign exmem_flush = w_exmem.flush;
  assign memwb_flush = w_memwb.flush;

  always_comb begin
    w_wait_nxt = '0;
    if (w_mem_wait) begin
      if (r_state == ST_RUN)
        w_wait_nxt = WAIT_W'(1);
      else if (r_wait_cnt == WAIT_MAX)
        w_wait_nxt = WAIT_MAX;
      else
        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  // The timeout flag is sticky; the freeze itself carries on until the access ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:      r_state <= w_mem_wait ? ST_MEM_WAIT : ST_RUN;
        ST_MEM_WAIT: r_state <= w_mem_wait ? ST_MEM_WAIT : ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt == WAIT_MAX)
        r_mem_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign dbg_state   = (r_state == ST_MEM_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;
  logic             w_any_flush;

  assign w_any_flush = w_ifid.flush | w_idex.flush | w_exmem.flush | w_memwb.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!pc_write)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_any_flush)
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8); counter expectations
// follow PIPE_CTRL_PERF_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rm, ex_mem_read, mem_branch_taken, mem_req, mem_ready;
  logic        pc_write, pc_sel_branch;
  logic        ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        mem_timeout, dbg_state;
  logic [31:0] stall_cycles, flush_events;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_write, pc_sel_branch, stalls ifid..memwb, flushes ifid..memwb, mem_timeout}
  logic [10:0] w_ctl;
  assign w_ctl = {pc_write, pc_sel_branch, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout};

  localparam logic [10:0] RUN_V = 11'b1_0_0000_0000_0;
  localparam logic [10:0] RST_V = 11'b0_0_0000_1111_0;
  localparam logic [10:0] LU_V  = 11'b0_0_1000_0100_0;
  localparam logic [10:0] BR_V  = 11'b1_1_0000_1110_0;
  localparam logic [10:0] MW_V  = 11'b0_0_1111_0000_0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] perf(input int n);
`ifdef PIPE_CTRL_PERF_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  // driver tasks; every task starts and ends 1 time unit after a rising edge
  task automatic drive_idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (w_ctl !== RST_V) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", w_ctl, RST_V); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    n_checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_events); end
    next_cycle();
    reset = 1'b1;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL first_run: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
    #1;
    n_checks++; if (w_ctl !== LU_V) begin n_fail++; $display("FAIL lu_rn: got %b want %b", w_ctl, LU_V); end
    next_cycle();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL lu_after: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rn = 5'd1; id_rm = 5'd7; id_uses_rm = 1'b1;
    #1;
    n_checks++; if (w_ctl !== LU_V) begin n_fail++; $display("FAIL lu_rm: got %b want %b", w_ctl, LU_V); end
    next_cycle();
    drive_idle();
    n_checks++; if (stall_cycles !== perf(2)) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cycles, perf(2)); end
    n_checks++; if (flush_events !== perf(2)) begin n_fail++; $display("FAIL lu_flush_cnt: got %0d want %0d", flush_events, perf(2)); end
  endtask

  task automatic test_xzr_unused();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd31; id_rn = 5'd31;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL xzr: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
    ex_rd = 5'd5; id_rn = 5'd0; id_rm = 5'd5; id_uses_rm = 1'b0;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL rm_unused: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
    ex_mem_read = 1'b0; ex_rd = 5'd3; id_rn = 5'd3;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL not_load: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
    drive_idle();
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL xzr_stall_cnt: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_branch();
    apply_reset();
    mem_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
    #1;
    n_checks++; if (w_ctl !== BR_V) begin n_fail++; $display("FAIL branch: got %b want %b", w_ctl, BR_V); end
    next_cycle();
    drive_idle();
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL branch_after: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
    n_checks++; if (flush_events !== perf(1)) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want %0d", flush_events, perf(1)); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL br_stall_cnt: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) mem_branch_taken = 1'b1;
      #1;
      n_checks++; if (w_ctl !== MW_V) begin n_fail++; $display("FAIL mw_freeze%0d: got %b want %b", k, w_ctl, MW_V); end
      n_checks++; if (dbg_state !== (k != 0)) begin n_fail++; $display("FAIL mw_state%0d: got %b want %b", k, dbg_state, (k != 0)); end
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (w_ctl !== BR_V) begin n_fail++; $display("FAIL mw_exit_branch: got %b want %b", w_ctl, BR_V); end
    next_cycle();
    drive_idle();
    #1;
    n_checks++; if (w_ctl !== RUN_V || dbg_state !== 1'b0) begin n_fail++; $display("FAIL mw_back_run: got %b/%b want %b/0", w_ctl, dbg_state, RUN_V); end
    n_checks++; if (stall_cycles !== perf(4)) begin n_fail++; $display("FAIL mw_stall_cnt: got %0d want %0d", stall_cycles, perf(4)); end
    n_checks++; if (flush_events !== perf(1)) begin n_fail++; $display("FAIL mw_flush_cnt: got %0d want %0d", flush_events, perf(1)); end
    next_cycle();
  endtask

  task automatic test_ready_same_cycle();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL ready_now: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
    drive_idle();
    n_checks++; if (dbg_state !== 1'b0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL ready_now_state: got %b/%0d want 0/0", dbg_state, stall_cycles); end
  endtask

  task automatic test_timeout();
    logic [10:0] exp_v;
    apply_reset();
    mem_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp_v = MW_V | {10'd0, (k >= 9)};
      #1;
      n_checks++; if (w_ctl !== exp_v) begin n_fail++; $display("FAIL timeout_cyc%0d: got %b want %b", k, w_ctl, exp_v); end
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (w_ctl !== (RUN_V | 11'd1)) begin n_fail++; $display("FAIL timeout_sticky: got %b want %b", w_ctl, RUN_V | 11'd1); end
    next_cycle();
    drive_idle();
    next_cycle();
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got %b want 1", mem_timeout); end
    n_checks++; if (stall_cycles !== perf(10)) begin n_fail++; $display("FAIL timeout_stall_cnt: got %0d want %0d", stall_cycles, perf(10)); end
    reset = 1'b0;
    #1;
    n_checks++; if (w_ctl !== RST_V) begin n_fail++; $display("FAIL timeout_reset: got %b want %b", w_ctl, RST_V); end
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    mem_req = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    n_checks++; if (dbg_state !== 1'b1 || w_ctl !== MW_V) begin n_fail++; $display("FAIL rmw_pre: got %b/%b want 1/%b", dbg_state, w_ctl, MW_V); end
    reset = 1'b0;
    #1;
    n_checks++; if (w_ctl !== RST_V) begin n_fail++; $display("FAIL rmw_outputs: got %b want %b", w_ctl, RST_V); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rmw_state: got %b want 0", dbg_state); end
    n_checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin n_fail++; $display("FAIL rmw_counters: got %0d/%0d want 0/0", stall_cycles, flush_events); end
    next_cycle();
    drive_idle();
    reset = 1'b1;
    #1;
    n_checks++; if (w_ctl !== RUN_V) begin n_fail++; $display("FAIL rmw_release: got %b want %b", w_ctl, RUN_V); end
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_load_use();
    test_xzr_unused();
    test_branch();
    test_mem_wait();
    test_ready_same_cycle();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage LEGv8 pipeline. Drives the PC write enable, the PC branch-select, and the per-stage stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, which are currently tied inactive. Handles three hazards:
- load-use, with a one-cycle bubble;
- taken branch resolved in MEM, with a three-stage flush;
- multi-cycle data-memory access, with a full-pipeline freeze through a ready handshake.

## Interface
- `MEM_TIMEOUT`, default 64: wait cycles before `mem_timeout` is raised.
- `CNT_W`, default 32: width of the performance counters.
- `clk  in  1`: pipeline clock.
- `reset  in  1`: asynchronous, active-low reset.
- `id_rn  in  5`: ID-stage first source register, IF/ID `ins[9:5]`.
- `id_rm  in  5`: ID-stage second source register, the output of the Reg2Loc mux.
- `id_uses_rm  in  1`: the ID instruction reads `id_rm`.
- `ex_mem_read  in  1`: ID/EX MemRead.
- `ex_rd  in  5`: ID/EX destination register.
- `mem_branch_taken  in  1`: EX/MEM Branch & Zero.
- `mem_req  in  1`: EX/MEM MemRead | MemWrite.
- `mem_ready  in  1`: data memory has completed the current access.
- `pc_write  out  1`: PC register enable.
- `pc_sel_branch  out  1`: selects the EX/MEM branch target into the PC.
- `ifid_stall`, `idex_stall`, `exmem_stall`, `memwb_stall`  `out  1` each: hold the stage register.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  `out  1` each: load the register with zero (bubble).
- `mem_timeout  out  1`: sticky error flag.
- `stall_cycles  out  CNT_W`: stall-cycle performance counter.
- `flush_events  out  CNT_W`: flush-event performance counter.

## Operation
States:
- **RUN**: normal issue.
- **MEM_WAIT**: an access is outstanding.

Outputs are Mealy: they depend on the current state and the current inputs, so a stall takes effect in the cycle its cause is visible.

Priority, highest first:
1. **Memory wait.** `mem_req=1` and `mem_ready=0`.
   - `pc_write=0`, all four stalls = 1, all flushes = 0, `pc_sel_branch=0`.
   - In RUN: move to MEM_WAIT and load the wait counter with 1.
   - In MEM_WAIT: increment the wait counter, saturating at `MEM_TIMEOUT`.
2. **Branch taken.** `mem_branch_taken=1`.
   - `pc_sel_branch=1`, `pc_write=1`.
   - `ifid_flush`, `idex_flush`, `exmem_flush` = 1. `memwb_flush=0`.
   - Load-use detection is ignored this cycle.
3. **Load-use.** All of the following hold:
   - `ex_mem_read=1` and `ex_rd≠31`;
   - `ex_rd==id_rn`, or (`id_uses_rm=1` and `ex_rd==id_rm`).

   Response: `pc_write=0`, `ifid_stall=1`, `idex_flush=1`. All other stalls and flushes = 0.
4. **Otherwise:** `pc_write=1`. All stalls, flushes and `pc_sel_branch` = 0.

State transitions and boundary cases:
- MEM_WAIT → RUN on `mem_ready=1`, or on `mem_req=0` (request withdrawn). The wait counter clears on the transition. The exit cycle is evaluated with RUN priorities 2–4.
- `mem_timeout` is set when the wait counter reaches `MEM_TIMEOUT`. It stays set until reset. The freeze continues after timeout; there is no forced completion.
- Simultaneous memory wait and branch: the wait wins. EX/MEM is frozen, so the branch is re-presented and taken once the wait ends.
- Register 31 (XZR) never causes a load-use stall.

## Timing
- Combinational path from inputs to stall/flush/PC outputs; no added pipeline latency.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 3 squashed instructions.
- Memory wait costs N stall cycles when `mem_ready` rises N cycles after `mem_req`. `mem_ready` in the same cycle as `mem_req` means 0 stall cycles.
- Reset asserted (low), asynchronously, regardless of mid-wait or mid-flush:
  - state = RUN, wait counter = 0, `mem_timeout=0`, counters = 0;
  - `pc_write=0`, all stalls = 0, all four flushes = 1, `pc_sel_branch=0`.
- First cycle after reset release: RUN, with `pc_write=1` if no hazard is present.

## Configuration
Macro `PIPE_CTRL_PERF_EN`.
- **Defined:**
  - `stall_cycles` increments on every cycle with `pc_write=0` outside reset.
  - `flush_events` increments on every cycle with any flush asserted outside reset.
  - Both wrap modulo 2^CNT_W.
- **Undefined:** the counter registers are not built, and both ports are tied to 0. All other behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MEM_WAIT);
  - the XZR register index constant (31);
  - a stage-control struct `{stall, flush}`.
- One sub-module, `load_use_detect`: purely combinational comparator producing the load-use hit.
- The FSM, wait counter and performance counters stay in the top module.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rd=3`, `id_rn=3` → exactly one cycle of `pc_write=0`, `ifid_stall=1`, `idex_flush=1`. Then normal flow.
- **XZR / unused operand:** `ex_rd=31` with `id_rn=31` → no stall. `ex_rd=5`, `id_rm=5`, `id_uses_rm=0` → no stall.
- **Branch:** `mem_branch_taken=1` for one cycle, with a concurrent load-use match → `pc_sel_branch=1`, IF/ID, ID/EX and EX/MEM flushed, no stall. `flush_events=1` with the macro defined.
- **Memory wait:** `mem_req=1`, `mem_ready` rising after 4 cycles → 4 cycles with all stalls = 1 and `pc_write=0`, then RUN. `stall_cycles=4`.
- **Timeout:** `MEM_TIMEOUT=8`, `mem_ready` held at 0 → `mem_timeout` rises on the 8th wait cycle and stays high after `mem_ready=1`, until reset.
- **Reset mid-wait:** assert `reset` low in the 3rd MEM_WAIT cycle → immediately RUN, all flushes = 1, counters = 0. After release, `pc_write=1`.
